float_to_int: RTL and testbench
===============================

Name: float_to_int

Overview:
- Iterative decoder that turns a reduced-format float_pack float into a signed two's-complement integer, truncating toward zero.
- It is the reverse of the coprocessor's integer/real-to-float encode path.
- It sits on the coprocessor result side behind a valid/ready handshake.
- It uses a one-bit-per-cycle barrel-free shifter, so the area stays small and the latency depends on the exponent.

Parameters:
- W_INT, 32, width of the integer result (must be ≥ N_mantisse+2).
- N_exposant and N_mantisse are not local parameters; they come from float_pack.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  op_in is valid.
- in_ready  out  1  block can accept an operand.
- op_in  in  1+N_exposant+N_mantisse  operand, type float_pack::float.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W_INT  signed integer result.
- ovf  out  1  magnitude exceeded the integer range; result is saturated.
- inexact  out  1  nonzero fraction bits were discarded.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, in_ready=0 during reset, out_valid=0, result=0, ovf=0, inexact=0, counter=0. Asserting reset mid-operation aborts the conversion; no result is produced.
- Definitions:
  - BIAS = 2^(N_exposant-1)-1.
  - e = exposant - BIAS, signed, N_exposant+1 bits.
  - mag = {1, mantisse} zero-extended to W_INT.
- FSM states: IDLE, SHIFT, DONE. in_ready = (state==IDLE).
- IDLE: on accept (in_valid && in_ready), decode op_in:
  - exposant==0 (zero/underflow encoding) → result=0, ovf=0, inexact=(mantisse!=0) → DONE.
  - e<0 → result=0, inexact=1 → DONE.
  - e ≥ W_INT-1:
    - If signe=1, e==W_INT-1 and mantisse==0 → result=-2^(W_INT-1), ovf=0.
    - Otherwise ovf=1, result=signe ? -2^(W_INT-1) : 2^(W_INT-1)-1, inexact=0.
    - Either case → DONE.
  - Otherwise load mag, dir = (e ≥ N_mantisse) ? LEFT : RIGHT, count = |e - N_mantisse|, clear the sticky bit, latch signe → SHIFT.
- SHIFT:
  - count≠0: shift mag one bit in dir and decrement count. On RIGHT, OR the outgoing LSB into sticky.
  - count==0: result = sign ? -mag : mag, inexact = sticky, ovf=0 → DONE.
- DONE: out_valid=1. result, ovf and inexact are held stable while out_ready=0. When out_valid && out_ready → IDLE, out_valid=0 next cycle.
- Latency, with the accept edge at cycle 0:
  - Special cases: out_valid at cycle 1.
  - Normal path: out_valid at cycle count+2.
  - No overlap: the next operand is accepted at the earliest one cycle after the result handshake.
- Width rules:
  - Counter width is $clog2(W_INT).
  - Maximum count is max(N_mantisse, W_INT-2-N_mantisse); left shifts never lose set bits by construction.
  - Negation is performed in W_INT bits.
- in_valid while not ready: the operand is ignored and must be held by the producer (standard valid/ready).

Decomposition:
- float_pack additions:
  - typedef enum f2i_state_t {IDLE, SHIFT, DONE}.
  - constant BIAS.
  - function float_bias_unbias(float) returning the signed e.
  - function real2int_ref(shortreal, int w) for the bench model.
- Sub-module f2i_shifter: holds mag/count/sticky with load, dir and step inputs, and outputs done (count==0). The FSM and handshake stay in float_to_int.

Test Plan:
All scenarios use N_exposant=5 and N_mantisse=10 (BIAS=15).
- 5.75 (exposant=17, mantisse=0111000000) accepted at cycle 0 → RIGHT count=8, out_valid at cycle 10, result=5, inexact=1, ovf=0.
- 1536.0 (exposant=25, mantisse=1000000000) → count=0, out_valid at cycle 2, result=1536, inexact=0. Then -3000.0 (signe=1, exposant=26, mantisse=0111011100) → LEFT count=1, out_valid at cycle 3, result=-3000.
- 0.5 (exposant=14) → result=0, inexact=1, out_valid at cycle 1. Zero encoding (exposant=0, mantisse=0) → result=0, inexact=0, out_valid at cycle 1.
- W_INT=16:
  - 32768.0 (exposant=30, mantisse=0) → result=32767, ovf=1.
  - -32768.0 → result=-32768, ovf=0.
  - -40000.0 → result=-32768, ovf=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid → result/flags stable, in_ready=0, a new in_valid is ignored. Releasing out_ready → IDLE next cycle, and the new operand is accepted.
- Reset pulse during SHIFT (cycle 4 of the 5.75 case) → out_valid stays 0, state=IDLE after reset release, and the next operand 2.0 converts to 2 with inexact=0.

Source files
------------

// File: rtl/float_pack.sv
// Shared definitions for the reduced float format used by the coprocessor:
// field layout, exponent bias, decoder FSM states and a reference conversion for models.
package float_pack;

    localparam int N_exposant = 5;
    localparam int N_mantisse = 10;
    localparam int BIAS       = 2 ** (N_exposant - 1) - 1;

    typedef struct packed {
        logic                  signe;
        logic [N_exposant-1:0] exposant;
        logic [N_mantisse-1:0] mantisse;
    } float;

    // Unbiased exponent carries one extra bit so every encoding fits as a signed value
    typedef logic signed [N_exposant:0] float_exp_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } f2i_state_t;

    localparam logic SHIFT_LEFT  = 1'b1;
    localparam logic SHIFT_RIGHT = 1'b0;

    function automatic float_exp_t float_bias_unbias(input float f);
        return float_exp_t'({1'b0, f.exposant}) - float_exp_t'(BIAS);
    endfunction

    // Truncate toward zero and saturate to a w-bit two's-complement range
    function automatic longint real2int_ref(input real x, input int w);
        real t;
        real lim;
        t   = (x >= 0.0) ? $floor(x) : -$floor(-x);
        lim = $pow(2.0, w - 1);
        if (t > lim - 1.0) return longint'(lim - 1.0);
        if (t < -lim) return longint'(-lim);
        return longint'(t);
    endfunction

endpackage

// File: rtl/f2i_shifter.sv
// One-bit-per-cycle magnitude shifter for the float decoder: a loadable
// mantissa register, a step counter, and a sticky bit collecting dropped bits.
module f2i_shifter
    import float_pack::*;
#(
    parameter int W_INT = 32,
    parameter int CNT_W = $clog2(W_INT)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dir,
    input  logic             step,
    input  logic [W_INT-1:0] mag_in,
    input  logic [CNT_W-1:0] count_in,
    output logic [W_INT-1:0] mag,
    output logic             sticky,
    output logic             done
);

    logic [CNT_W-1:0] count;
    logic             dir_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mag    <= '0;
            count  <= '0;
            sticky <= 1'b0;
            dir_q  <= SHIFT_RIGHT;
        end else if (load) begin
            mag    <= mag_in;
            count  <= count_in;
            sticky <= 1'b0;
            dir_q  <= dir;
        end else if (step && !done) begin
            count <= count - CNT_W'(1);
            if (dir_q == SHIFT_LEFT) begin
                mag <= mag << 1;
            end else begin
                // Right shifts drop fraction bits; remember whether any were set
                mag    <= mag >> 1;
                sticky <= sticky | mag[0];
            end
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/float_to_int.sv
// Iterative float_pack -> signed integer decoder (truncate toward zero) behind
// valid/ready on both sides; special encodings resolve in one cycle, others shift.
module float_to_int
    import float_pack::*;
#(
    parameter int W_INT = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  float                    op_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W_INT-1:0] result,
    output logic                    ovf,
    output logic                    inexact
);

    localparam int CNT_W = $clog2(W_INT);
    localparam int EW    = N_exposant + 2;

    localparam logic [W_INT-1:0] INT_MIN = {1'b1, {(W_INT - 1){1'b0}}};
    localparam logic [W_INT-1:0] INT_MAX = {1'b0, {(W_INT - 1){1'b1}}};

    f2i_state_t state;
    f2i_state_t state_nxt;

    float_exp_t            e;
    logic signed [EW-1:0]  e_off;
    logic [CNT_W-1:0]      cnt_load;
    logic                  dir_load;
    logic                  zero_enc;
    logic                  e_neg;
    logic                  e_big;
    logic                  is_int_min;
    logic                  special;
    logic                  accept;

    logic                  sign_q;
    logic                  sh_load;
    logic                  sh_step;
    logic                  sh_done;
    logic                  sh_sticky;
    logic [W_INT-1:0]      sh_mag;

    // Operand decode: unbiased exponent and distance from the binary point
    assign e          = float_bias_unbias(op_in);
    assign e_off      = {e[N_exposant], e} - EW'(N_mantisse);
    assign dir_load   = e_off[EW-1] ? SHIFT_RIGHT : SHIFT_LEFT;
    assign cnt_load   = CNT_W'(e_off[EW-1] ? -e_off : e_off);
    assign zero_enc   = (op_in.exposant == '0);
    assign e_neg      = e[N_exposant];
    assign e_big      = (int'(e) >= W_INT - 1);
    // The most negative integer is representable even though its exponent is out of range
    assign is_int_min = op_in.signe && (int'(e) == W_INT - 1) && (op_in.mantisse == '0);
    assign special    = zero_enc || e_neg || e_big;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = special ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (sh_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && reset_n;
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
        sh_load   = accept && !special;
        sh_step   = (state == SHIFT);
    end

    // Result/flag registers: written on special-case accept or at the end of shifting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result  <= '0;
            ovf     <= 1'b0;
            inexact <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q <= op_in.signe;
                        if (zero_enc) begin
                            result  <= '0;
                            ovf     <= 1'b0;
                            inexact <= |op_in.mantisse;
                        end else if (e_neg) begin
                            result  <= '0;
                            ovf     <= 1'b0;
                            inexact <= 1'b1;
                        end else if (e_big) begin
                            inexact <= 1'b0;
                            if (is_int_min) begin
                                result <= INT_MIN;
                                ovf    <= 1'b0;
                            end else begin
                                result <= op_in.signe ? INT_MIN : INT_MAX;
                                ovf    <= 1'b1;
                            end
                        end
                    end
                end
                SHIFT: begin
                    if (sh_done) begin
                        result  <= sign_q ? -sh_mag : sh_mag;
                        ovf     <= 1'b0;
                        inexact <= sh_sticky;
                    end
                end
                default: ;
            endcase
        end
    end

    f2i_shifter #(
        .W_INT (W_INT),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (sh_load),
        .dir      (dir_load),
        .step     (sh_step),
        .mag_in   (W_INT'({1'b1, op_in.mantisse})),
        .count_in (cnt_load),
        .mag      (sh_mag),
        .sticky   (sh_sticky),
        .done     (sh_done)
    );

endmodule

// File: tb/tb_float_to_int.sv
// Bench for float_to_int at W_INT=32 and W_INT=16: real-arithmetic reference model,
// per-cycle output comparison, directed corner cases, backpressure, reset abort, random traffic.
`timescale 1ns/1ps
module tb_float_to_int;
    import float_pack::*;

    typedef struct {
        longint res;
        bit     ovf;
        bit     inx;
        int     lat;
        int     acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic iv32, ir32, ov32, or32, ovf32, inx32;
    float op32;
    logic signed [31:0] res32;
    logic iv16, ir16, ov16, or16, ovf16, inx16;
    float op16;
    logic signed [15:0] res16;

    float_to_int #(.W_INT(32)) d32 (
        .clk(clk), .reset_n(rst_n), .in_valid(iv32), .in_ready(ir32), .op_in(op32),
        .out_valid(ov32), .out_ready(or32), .result(res32), .ovf(ovf32), .inexact(inx32));
    float_to_int #(.W_INT(16)) d16 (
        .clk(clk), .reset_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op_in(op16),
        .out_valid(ov16), .out_ready(or16), .result(res16), .ovf(ovf16), .inexact(inx16));

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q32[$];
    exp_t q16[$];
    bit   first32 = 1'b1;
    bit   first16 = 1'b1;
    bit   rand_rdy = 1'b0;
    bit   hold32 = 1'b1;
    bit   hold16 = 1'b1;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        or32 = rand_rdy ? ($urandom_range(0, 3) != 0) : hold32;
        or16 = rand_rdy ? ($urandom_range(0, 3) != 0) : hold16;
    end

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", nm, $time);
    endtask

    function automatic float mk(input bit s, input int ex, input int m);
        float f;
        f.signe    = s;
        f.exposant = N_exposant'(ex);
        f.mantisse = N_mantisse'(m);
        return f;
    endfunction

    // Reference: value of the encoding as a real, then truncate/saturate
    function automatic exp_t model(input float f, input int w);
        exp_t r;
        real  v, tr, lim;
        int   e;
        e     = int'(f.exposant) - BIAS;
        r.acc = 0;
        if (f.exposant == 0) begin
            r.res = 0; r.ovf = 0; r.inx = (f.mantisse != 0); r.lat = 1;
            return r;
        end
        v = (1.0 + real'(f.mantisse) / $pow(2.0, N_mantisse)) * $pow(2.0, e);
        if (f.signe) v = -v;
        tr    = (v >= 0.0) ? $floor(v) : -$floor(-v);
        lim   = $pow(2.0, w - 1);
        r.res = real2int_ref(v, w);
        r.ovf = (tr > lim - 1.0) || (tr < -lim);
        r.inx = !r.ovf && (tr != v);
        r.lat = (e < 0 || e >= w - 1) ? 1 : (((e >= N_mantisse) ? e - N_mantisse : N_mantisse - e) + 2);
        return r;
    endfunction

    function automatic float rnd_float();
        float f;
        f.signe    = 1'($urandom_range(0, 1));
        f.exposant = N_exposant'($urandom_range(0, 2 ** N_exposant - 1));
        f.mantisse = ($urandom_range(0, 3) == 0) ? '0 : N_mantisse'($urandom);
        return f;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q32.delete();
            first32 = 1'b1;
        end else if (ov32 === 1'b1) begin
            chk("in_ready_while_valid32", ir32, 0);
            if (q32.size() == 0) fail("unexpected_valid32");
            else begin
                chk("res32", res32, q32[0].res);
                chk("ovf32", ovf32, q32[0].ovf);
                chk("inexact32", inx32, q32[0].inx);
                if (first32) chk("latency32", cyc - q32[0].acc + 1, q32[0].lat);
                first32 = 1'b0;
                if (or32) begin
                    void'(q32.pop_front());
                    first32 = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q16.delete();
            first16 = 1'b1;
        end else if (ov16 === 1'b1) begin
            chk("in_ready_while_valid16", ir16, 0);
            if (q16.size() == 0) fail("unexpected_valid16");
            else begin
                chk("res16", res16, q16[0].res);
                chk("ovf16", ovf16, q16[0].ovf);
                chk("inexact16", inx16, q16[0].inx);
                if (first16) chk("latency16", cyc - q16[0].acc + 1, q16[0].lat);
                first16 = 1'b0;
                if (or16) begin
                    void'(q16.pop_front());
                    first16 = 1'b1;
                end
            end
        end
    end

    // Called at posedge+1; returns after the accepting edge, acc = that edge's cycle number
    task automatic send(input int d, input float op, output int acc);
        exp_t e;
        bit   got;
        got = 1'b0;
        acc = -1;
        e   = model(op, (d == 0) ? 32 : 16);
        if (d == 0) begin iv32 = 1'b1; op32 = op; end
        else begin iv16 = 1'b1; op16 = op; end
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (rst_n && ((d == 0) ? ir32 : ir16)) begin
                e.acc = cyc + 1;
                acc   = e.acc;
                if (d == 0) q32.push_back(e); else q16.push_back(e);
                got = 1'b1;
            end
        end
        if (!got) fail("accept_timeout");
        @(posedge clk); #1;
        if (d == 0) iv32 = 1'b0; else iv16 = 1'b0;
    endtask

    task automatic expect_out(input int d, input longint r, input bit o, input bit x);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if ((d == 0) ? ov32 : ov16) seen = 1'b1;
        end
        if (!seen) fail("result_timeout");
        else if (d == 0) begin
            chk("lit_res32", res32, r); chk("lit_ovf32", ovf32, o); chk("lit_inx32", inx32, x);
        end else begin
            chk("lit_res16", res16, r); chk("lit_ovf16", ovf16, o); chk("lit_inx16", inx16, x);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t m;
        int   a;
        int   c;
        bit   seen;
        iv32 = 1'b0; iv16 = 1'b0; op32 = '0; op16 = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready32", ir32, 0);   chk("rst_out_valid32", ov32, 0);
        chk("rst_result32", res32, 0);    chk("rst_ovf32", ovf32, 0);
        chk("rst_inexact32", inx32, 0);   chk("rst_in_ready16", ir16, 0);
        chk("rst_out_valid16", ov16, 0);  chk("rst_result16", res16, 0);

        m = model(mk(0, 17, 448), 32);
        chk("pin_5p75_res", m.res, 5); chk("pin_5p75_inx", m.inx, 1); chk("pin_5p75_lat", m.lat, 10);
        m = model(mk(1, 26, 476), 32);
        chk("pin_m3000_res", m.res, -3000); chk("pin_m3000_lat", m.lat, 3);
        m = model(mk(0, 14, 0), 32);
        chk("pin_0p5_inx", m.inx, 1); chk("pin_0p5_lat", m.lat, 1);
        m = model(mk(0, 30, 0), 16);
        chk("pin_32768_res", m.res, 32767); chk("pin_32768_ovf", m.ovf, 1);
        m = model(mk(1, 30, 0), 16);
        chk("pin_m32768_res", m.res, -32768); chk("pin_m32768_ovf", m.ovf, 0);
        m = model(mk(1, 30, 226), 16);
        chk("pin_m40000_res", m.res, -32768); chk("pin_m40000_ovf", m.ovf, 1);

        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        send(0, mk(0, 17, 448), a);  expect_out(0, 5, 0, 1);
        send(0, mk(0, 25, 512), a);  expect_out(0, 1536, 0, 0);
        send(0, mk(1, 26, 476), a);  expect_out(0, -3000, 0, 0);
        send(0, mk(0, 14, 0), a);    expect_out(0, 0, 0, 1);
        send(0, mk(0, 0, 0), a);     expect_out(0, 0, 0, 0);
        send(1, mk(0, 30, 0), a);    expect_out(1, 32767, 1, 0);
        send(1, mk(1, 30, 0), a);    expect_out(1, -32768, 0, 0);
        send(1, mk(1, 30, 226), a);  expect_out(1, -32768, 1, 0);

        // Backpressure: result held, new operand ignored until the handshake
        hold32 = 1'b0;
        @(posedge clk); #1;
        send(0, mk(0, 17, 448), a);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ov32) seen = 1'b1;
        end
        if (!seen) fail("bp_valid_timeout");
        iv32 = 1'b1; op32 = mk(0, 25, 512);
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", ir32, 0);
            chk("bp_out_valid", ov32, 1);
        end
        @(posedge clk); #1;
        hold32 = 1'b1;
        c = cyc;
        send(0, mk(0, 25, 512), a);
        chk("bp_accept_cycle", a, c + 2);
        expect_out(0, 1536, 0, 0);

        // Reset in the middle of a shift aborts the conversion
        send(0, mk(0, 17, 448), a);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", ov32, 0); chk("mid_rst_in_ready", ir32, 0);
        chk("mid_rst_result", res32, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            chk("post_rst_out_valid", ov32, 0);
            chk("post_rst_in_ready", ir32, 1);
        end
        @(posedge clk); #1;
        send(0, mk(0, 16, 0), a);    expect_out(0, 2, 0, 0);

        rand_rdy = 1'b1;
        fork
            begin
                for (int i = 0; i < 120; i++) begin
                    int aa;
                    send(0, rnd_float(), aa);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
            begin
                for (int i = 0; i < 120; i++) begin
                    int aa;
                    send(1, rnd_float(), aa);
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
            end
        join

        c = 0;
        while ((q32.size() != 0 || q16.size() != 0) && c < 3000) begin
            @(posedge clk);
            c++;
        end
        if (c >= 3000) fail("drain_timeout");
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
